// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_port_arbiter: shares one single-ported memory bus between the     |
// | IF and DM ports; DM first, with a streak limit so IF is not starved.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int DM_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_dm
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_DM = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [3:0] BURST_MAX = 4'(DM_BURST_MAX);

  state_t      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic        served_dm_q, served_dm_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      streak_q    <= 4'd0;
      served_dm_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      served_dm_q <= served_dm_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    served_dm_d = served_dm_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      IDLE: begin
        // DM wins unless IF has already watched BURST_MAX DM grants in a row
        if (dm_req && !(if_req && streak_q == BURST_MAX)) begin
          state_d     = SERVE_DM;
          served_dm_d = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_be_d    = dm_be;
          if (!if_req)
            streak_d = 4'd0;
          else if (streak_q >= BURST_MAX)
            streak_d = BURST_MAX;
          else
            streak_d = streak_q + 4'd1;
        end else if (if_req) begin
          state_d     = SERVE_IF;
          served_dm_d = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = 32'd0;
          mem_be_d    = 4'b1111;
          streak_d    = 4'd0;
        end
      end
      SERVE_IF: begin
        if (mem_ack) begin
          state_d    = DONE;
          if_rdata_d = mem_rdata;
        end
      end
      SERVE_DM: begin
        if (mem_ack) begin
          state_d = DONE;
          if (!mem_we_q)
            dm_rdata_d = mem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_req   = (state_q == SERVE_IF) || (state_q == SERVE_DM);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = (state_q == DONE) && !served_dm_q;
  assign dm_ready  = (state_q == DONE) && served_dm_q;

  // Gated by rst_n so every output reads 0 while reset is held.
  assign stall_if  = rst_n && if_req && !if_ready;
  assign stall_dm  = rst_n && dm_req && !dm_ready;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Self-checking bench for mem_port_arbiter: directed test-plan steps plus a
// randomized phase checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_be;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, dm_ready, mem_req, mem_we, stall_if, stall_dm;
  logic [3:0]  mem_be;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_streak;
  logic [31:0] m_if_rdata, m_dm_rdata;

  mem_port_arbiter #(.DM_BURST_MAX(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_dm(stall_dm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One full access starting in an IDLE cycle: arbitration, w wait cycles,
  // then the DONE cycle. The model predicts the winner from the rules.
  task automatic xact(input int w, input logic [31:0] rdata, output bit dm_won);
    bit          exp_dm;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    exp_dm = dm_req && !(if_req && m_streak == MAX);
    if (exp_dm) begin
      e_we = dm_we; e_addr = dm_addr; e_wdata = dm_wdata; e_be = dm_be;
      m_streak = if_req ? ((m_streak >= MAX) ? MAX : m_streak + 1) : 0;
    end else begin
      e_we = 1'b0; e_addr = if_addr; e_wdata = 32'd0; e_be = 4'hF;
      m_streak = 0;
    end
    @(negedge clk);
    check("idle_mem_req", mem_req, 0);
    check("idle_stall_if", stall_if, if_req);
    check("idle_stall_dm", stall_dm, dm_req);
    next_cycle();
    for (int i = 0; i <= w; i++) begin
      mem_ack   = (i == w);
      mem_rdata = (i == w) ? rdata : $urandom;
      @(negedge clk);
      check("serve_mem_req", mem_req, 1);
      check("serve_mem_we", mem_we, e_we);
      check("serve_mem_addr", mem_addr, e_addr);
      check("serve_mem_wdata", mem_wdata, e_wdata);
      check("serve_mem_be", mem_be, e_be);
      check("serve_readies", {if_ready, dm_ready}, 0);
      check("serve_stall_if", stall_if, if_req);
      check("serve_stall_dm", stall_dm, dm_req);
      next_cycle();
    end
    if (exp_dm && !e_we) m_dm_rdata = rdata;
    if (!exp_dm)         m_if_rdata = rdata;
    mem_ack   = 1'($urandom);
    mem_rdata = $urandom;
    @(negedge clk);
    check("done_if_ready", if_ready, !exp_dm);
    check("done_dm_ready", dm_ready, exp_dm);
    check("done_mem_req", mem_req, 0);
    check("done_if_rdata", if_rdata, m_if_rdata);
    check("done_dm_rdata", dm_rdata, m_dm_rdata);
    check("done_stall_if", stall_if, if_req && exp_dm);
    check("done_stall_dm", stall_dm, dm_req && !exp_dm);
    dm_won = exp_dm;
    next_cycle();
  endtask

  task automatic new_dm(input logic we);
    dm_req = 1'b1; dm_we = we;
    dm_addr = $urandom & 32'hFFFF_FFFC; dm_wdata = $urandom; dm_be = 4'($urandom);
  endtask

  initial begin
    bit g;
    bit starve_exp [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0; if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0; mem_rdata = 0;
    m_streak = 0; m_if_rdata = 0; m_dm_rdata = 0;
    next_cycle(); next_cycle();
    @(negedge clk);
    check("rst_outputs", {mem_req, mem_we, mem_be, if_ready, dm_ready, stall_if, stall_dm}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_rdata", if_rdata, 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Single zero-wait fetch
    if_req = 1'b1; if_addr = 32'h0000_0040;
    xact(0, 32'h2008_0005, g);
    check("fetch_grant_dm", g, 0);
    check("fetch_rdata", if_rdata, 32'h2008_0005);
    if_req = 1'b0;

    // DM load, then a store with 3 wait cycles that must leave dm_rdata alone
    new_dm(1'b0);
    xact(1, 32'hCAFE_0001, g);
    dm_req = 1'b0;
    next_cycle();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011;
    xact(3, 32'h1234_5678, g);
    check("store_dm_rdata", dm_rdata, 32'hCAFE_0001);
    dm_req = 1'b0;

    // Simultaneous requests: DM first, IF in the following IDLE cycle
    if_req = 1'b1; if_addr = 32'h0000_0080;
    new_dm(1'b0);
    xact(0, $urandom, g);
    check("simul_first_dm", g, 1);
    dm_req = 1'b0;
    xact(0, $urandom, g);
    check("simul_second_if", g, 0);

    // Starvation guard: both ports keep requesting back to back
    if_req = 1'b1; if_addr = 32'h0000_0100;
    new_dm(1'b0);
    for (int i = 0; i < 6; i++) begin
      xact(int'($urandom_range(0, 1)), $urandom, g);
      check("starve_grant", g, starve_exp[i]);
      if (g) new_dm(1'($urandom));
      else   if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if_req = 1'b0; dm_req = 1'b0;
    next_cycle();

    // Reset while a DM access waits for mem_ack
    new_dm(1'b0);
    mem_ack = 1'b0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("pre_rst_mem_req", mem_req, 1);
    next_cycle();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {mem_req, mem_we, mem_be, if_ready, dm_ready, stall_if, stall_dm}, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_mem_wdata", mem_wdata, 0);
    check("midrst_rdata", if_rdata | dm_rdata, 0);
    dm_req = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    m_streak = 0; m_if_rdata = 0; m_dm_rdata = 0;
    if_req = 1'b1; if_addr = 32'h0000_0200;
    xact(1, 32'h0BAD_F00D, g);
    check("post_rst_fetch", if_rdata, 32'h0BAD_F00D);
    if_req = 1'b0;

    // Randomized traffic
    for (int k = 0; k < 60; k++) begin
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dm_req && $urandom_range(0, 2) != 0) new_dm(1'($urandom));
      if (!if_req && !dm_req) begin
        @(negedge clk);
        check("rand_idle", {mem_req, if_ready, dm_ready}, 0);
        next_cycle();
      end else begin
        xact(int'($urandom_range(0, 3)), $urandom, g);
        if (g) dm_req = 1'b0;
        else   if_req = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter sharing one single-ported memory bus between the instruction-fetch (IF) port and the data-memory (DM) port of the pipelined MIPS core. It serialises requests, sequences the memory handshake and returns per-port completion pulses. While a port's access is outstanding, it drives stall requests that the hazard unit ORs into its stall/flush logic. DM has priority, as it belongs to the older instruction; a streak limit keeps IF from being starved.

## Interface
- DM_BURST_MAX, 4: maximum number of consecutive DM grants made while IF is waiting. Range 1..15.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_ready.
- if_addr  in  32  fetch address; stable while if_req is high.
- if_rdata  out  32  fetched word; registered.
- if_ready  out  1  one-cycle completion pulse for the fetch.
- dm_req  in  1  data request; held high until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_be  in  4  store byte enables.
- dm_rdata  out  32  load data; registered.
- dm_ready  out  1  one-cycle completion pulse for the data access.
- mem_req  out  1  bus request; held until mem_ack.
- mem_we, mem_addr, mem_wdata, mem_be  out  1/32/32/4  registered bus command.
- mem_ack  in  1  bus completion; read data is valid in the same cycle.
- mem_rdata  in  32  bus read data.
- stall_if  out  1  combinational: if_req && !if_ready.
- stall_dm  out  1  combinational: dm_req && !dm_ready.

## Operation
- States are IDLE, SERVE_IF, SERVE_DM and DONE.
- IDLE with neither request pending: stay in IDLE.
- IDLE with only dm_req: grant DM. With only if_req: grant IF.
- IDLE with both requests: grant DM unless streak == DM_BURST_MAX; in that case grant IF.
- On a grant, the command is latched into the mem_* registers and the FSM moves to SERVE_x.
- IF command: mem_we=0, mem_be=4'b1111, mem_wdata=0, mem_addr=if_addr.
- DM command: dm_we, dm_be, dm_wdata and dm_addr are copied to the bus.
- SERVE_x holds mem_req=1 and keeps the command stable until mem_ack=1.
- On the mem_ack edge, the FSM moves to DONE and mem_req drops.
  - Serving IF: if_rdata <= mem_rdata.
  - Serving a DM load: dm_rdata <= mem_rdata.
  - Serving a DM store: dm_rdata is unchanged.
- DONE: the served port's x_ready is 1 for exactly this cycle. No arbitration happens in DONE. Next state is IDLE.
- Streak counter (4 bits), updated at the grant edge:
  - DM grant with if_req high: streak increments, saturating at DM_BURST_MAX.
  - DM grant with if_req low: streak clears to 0.
  - IF grant: streak clears to 0.
- mem_ack is ignored outside SERVE_x.
- Requests that change during SERVE_x or DONE are ignored until IDLE.
- if_rdata and dm_rdata hold their values until the next capture.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, streak=0, and all outputs are 0. This includes mem_req, which drops immediately even mid-transaction. An outstanding bus transaction is abandoned; the memory side must tolerate this.
- Zero-wait access:
  - Request high in cycle 0 (IDLE).
  - Cycle 1: mem_req=1, mem_ack=1.
  - Cycle 2: DONE, x_ready=1.
  - Cycle 3: IDLE; a new grant is possible at the end of cycle 3.
- Latency is 2 + W cycles from request to ready, where W is the number of wait cycles before mem_ack.
- Peak throughput is one access per 3 cycles.
- stall_x is high from the first cycle x_req is high through the cycle before x_ready, and low in the x_ready cycle.
- A request arriving during SERVE or DONE waits; its first grant opportunity is the next IDLE cycle.

## Test plan
- Single fetch, zero wait:
  - Stimulus: if_req=1, if_addr=0x0000_0040, mem_rdata=0x2008_0005, mem_ack immediate.
  - Required: mem_req in cycle 1 with mem_addr=0x40, mem_we=0; if_ready and if_rdata=0x2008_0005 in cycle 2; stall_if=1 in cycles 0-1.
- DM store with 3 wait cycles:
  - Stimulus: dm_we=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF, dm_be=4'b0011.
  - Required: command stable for 4 cycles; dm_ready in cycle 5; dm_rdata unchanged.
- Simultaneous if_req and dm_req, streak=0:
  - Required: DM served first; IF granted in the following IDLE cycle; if_ready 3 cycles after dm_ready.
- Starvation guard with DM_BURST_MAX=2:
  - Stimulus: dm_req held continuously with if_req high.
  - Required: grant sequence DM, DM, IF, DM, DM, IF.
- Reset mid-transaction:
  - Stimulus: rst_n pulled low during SERVE_DM while mem_ack is withheld.
  - Required: mem_req=0 and all outputs 0 immediately; after release, a fresh if_req is served normally.
